// File: rtl/load_count_pkg.sv
// ---------------------------------------------------------------------------
// load_count_pkg
// Shared constants for the load/count register family.
//   DIR_UP / DIR_DN : values of the 'up' direction input
//   op_e            : per-cycle operation selected by the priority decoder
//   DEFAULT_WIDTH   : default data width of the counter
// ---------------------------------------------------------------------------
package load_count_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_CLR  = 2'd1,
        OP_LOAD = 2'd2,
        OP_CNT  = 2'd3
    } op_e;

endpackage

// File: rtl/load_count_prescaler.sv
// ---------------------------------------------------------------------------
// load_count_prescaler
// Modulo-PRE_DIV counter that thins the count enable: tick is high on every
// PRE_DIV-th enabled cycle.
//   clk, rst (async, active-low), clr (sync clear)
//   hold     : freezes the counter (used while the parent is loading)
//   en       : raw count enable
//   tick     : qualified enable for the parent counter, also exported
// ---------------------------------------------------------------------------
module load_count_prescaler #(
    parameter int PRE_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRE_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // tick is combinational from the registered phase so that it lines up
    // with the cycle in which the parent samples the qualified enable.
    assign tick = en && !hold && !clr && (cnt_reg == LAST);

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (!hold && en) begin
            cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/load_count_reg.sv
// ---------------------------------------------------------------------------
// load_count_reg
// Holds, loads or counts up/down a WIDTH-bit value against a programmable
// limit, wrapping (SATURATE=0) or saturating (SATURATE=1) at the ends.
// Optional build macro PRESCALE_EN adds a modulo-PRE_DIV enable prescaler
// and the pre_tick output.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active-low
//   clr   : synchronous clear to RST_VAL (highest priority)
//   load  : synchronous load of 'in'
//   en    : count enable
//   up    : 1 = increment, 0 = decrement
//   in    : load data
//   limit : terminal value, sampled every cycle
//   out   : registered count
//   tc    : registered one-cycle terminal-count pulse
//   ovf   : sticky overflow/underflow flag (cleared by rst or clr)
//   pre_tick (PRESCALE_EN only) : prescaler step pulse
// ---------------------------------------------------------------------------
module load_count_reg
    import load_count_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               SATURATE = 0
`ifdef PRESCALE_EN
    ,
    parameter int               PRE_DIV  = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
`ifdef PRESCALE_EN
    ,
    output logic             pre_tick
`endif
);

    logic [WIDTH-1:0] out_reg, out_next;
    logic             tc_reg, tc_next;
    logic             ovf_reg, ovf_next;
    logic             step;
    op_e              op;

`ifdef PRESCALE_EN
    load_count_prescaler #(
        .PRE_DIV (PRE_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .hold (load),
        .en   (en),
        .tick (step)
    );
    assign pre_tick = step;
`else
    assign step = en;
`endif

    always_comb begin
        if (clr)       op = OP_CLR;
        else if (load) op = OP_LOAD;
        else if (step) op = OP_CNT;
        else           op = OP_HOLD;
    end

    always_comb begin
        out_next = out_reg;
        tc_next  = 1'b0;
        ovf_next = ovf_reg;
        case (op)
            OP_CLR: begin
                out_next = RST_VAL;
                ovf_next = 1'b0;
            end
            OP_LOAD: begin
                out_next = in;
            end
            OP_CNT: begin
                if (up == DIR_UP) begin
                    // >= so that a value loaded above limit is terminal too
                    if (out_reg >= limit) begin
                        out_next = (SATURATE != 0) ? limit : '0;
                        tc_next  = 1'b1;
                        ovf_next = 1'b1;
                    end else begin
                        out_next = out_reg + 1'b1;
                    end
                end else begin
                    if (out_reg == '0) begin
                        out_next = (SATURATE != 0) ? '0 : limit;
                        tc_next  = 1'b1;
                        ovf_next = 1'b1;
                    end else begin
                        out_next = out_reg - 1'b1;
                    end
                end
            end
            default: begin
                out_next = out_reg;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_reg <= RST_VAL;
            tc_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            tc_reg  <= tc_next;
            ovf_reg <= ovf_next;
        end
    end

    assign out = out_reg;
    assign tc  = tc_reg;
    assign ovf = ovf_reg;

endmodule

// File: tb/tb_load_count_reg.sv
module tb_load_count_reg;
    import load_count_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic [W-1:0] in = '0;
    logic [W-1:0] limit = '0;

    logic [W-1:0] out_w, out_s;
    logic         tc_w, tc_s, ovf_w, ovf_s;
`ifdef PRESCALE_EN
    logic         pt_w, pt_s;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_count_reg #(.WIDTH(W), .RST_VAL('0), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .up(up),
        .in(in), .limit(limit), .out(out_w), .tc(tc_w), .ovf(ovf_w)
`ifdef PRESCALE_EN
        , .pre_tick(pt_w)
`endif
    );

    load_count_reg #(.WIDTH(W), .RST_VAL('0), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .up(up),
        .in(in), .limit(limit), .out(out_s), .tc(tc_s), .ovf(ovf_s)
`ifdef PRESCALE_EN
        , .pre_tick(pt_s)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_up [6];
        logic [W-1:0] exp_sat [6];
        exp_up  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        exp_sat = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};

        // 1: reset held with load pending
        rst = 1'b0; in = 8'd7; load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_out%0d", i), out_w, 0);
            chk($sformatf("rst_tc%0d", i), tc_w, 0);
            chk($sformatf("rst_ovf%0d", i), ovf_w, 0);
        end
        rst = 1'b1;
        tick();
        chk("rst_release_load", out_w, 7);
        load = 1'b0;

        // 2: up-count wrap at limit 5
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_out", out_w, 0);
        limit = 8'd5; up = DIR_UP; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("up_out%0d", i), out_w, exp_up[i]);
            chk($sformatf("up_tc%0d", i), tc_w, (i == 5) ? 1 : 0);
            chk($sformatf("up_ovf%0d", i), ovf_w, (i == 5) ? 1 : 0);
        end
        en = 1'b0;
        tick();
        chk("up_hold_tc", tc_w, 0);
        chk("up_hold_ovf", ovf_w, 1);
        chk("up_hold_out", out_w, 0);

        // 3: down-count wrap, ovf still sticky from before
        in = 8'd2; load = 1'b1; tick(); load = 1'b0;
        chk("dn_load", out_w, 2);
        chk("dn_load_ovf", ovf_w, 1);
        limit = 8'd9; up = DIR_DN; en = 1'b1;
        tick(); chk("dn_out0", out_w, 1); chk("dn_tc0", tc_w, 0);
        tick(); chk("dn_out1", out_w, 0); chk("dn_tc1", tc_w, 0);
        tick(); chk("dn_out2", out_w, 9); chk("dn_tc2", tc_w, 1);
        chk("dn_ovf", ovf_w, 1);
        tick(); chk("dn_out3", out_w, 8); chk("dn_tc3", tc_w, 0);
        en = 1'b0;

        // 4: saturating instance, limit 3
        clr = 1'b1; tick(); clr = 1'b0;
        limit = 8'd3; up = DIR_UP; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("sat_out%0d", i), out_s, exp_sat[i]);
            chk($sformatf("sat_tc%0d", i), tc_s, (i >= 3) ? 1 : 0);
        end
        chk("sat_ovf", ovf_s, 1);
        // saturating down at zero
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        chk("sat_clr_out", out_s, 0);
        chk("sat_clr_ovf", ovf_s, 0);
        up = DIR_DN; en = 1'b1;
        tick();
        chk("sat_dn_out", out_s, 0);
        chk("sat_dn_tc", tc_s, 1);
        chk("wrap_dn0_out", out_w, 3);

        // limit 0 counting up: tc every enabled cycle, out stays 0
        en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        limit = 8'd0; up = DIR_UP; en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("lim0_out%0d", i), out_w, 0);
            chk($sformatf("lim0_tc%0d", i), tc_w, 1);
        end
        // value loaded above limit is terminal on the next step
        limit = 8'd5; in = 8'd9; load = 1'b1; en = 1'b1; tick(); load = 1'b0;
        chk("over_load", out_w, 9);
        chk("over_load_tc", tc_w, 0);
        tick();
        chk("over_step_out", out_w, 0);
        chk("over_step_tc", tc_w, 1);
        en = 1'b0;

        // 5: priority
        limit = 8'd100; in = 8'd20; load = 1'b1; en = 1'b1;
        tick();
        chk("prio_load_en", out_w, 20);
        clr = 1'b1;
        tick();
        chk("prio_clr", out_w, 0);
        chk("prio_clr_ovf", ovf_w, 0);
        clr = 1'b0; load = 1'b0; en = 1'b0;

        // 6: async reset between edges
        in = 8'd4; load = 1'b1; tick(); load = 1'b0;
        chk("async_pre", out_w, 4);
        #2 rst = 1'b0;
        #1 chk("async_out", out_w, 0);
        #1 rst = 1'b1;
        tick();
        // reset while a tc pulse is visible
        limit = 8'd2; in = 8'd2; load = 1'b1; tick(); load = 1'b0;
        en = 1'b1; up = DIR_UP; tick(); en = 1'b0;
        chk("async_tc_pre", tc_w, 1);
        #2 rst = 1'b0;
        #1 chk("async_tc_drop", tc_w, 0);
        chk("async_ovf_drop", ovf_w, 0);
        #1 rst = 1'b1;
        tick();

`ifdef PRESCALE_EN
        // prescaler, default PRE_DIV = 4
        clr = 1'b1; tick(); clr = 1'b0;
        limit = 8'd100; up = DIR_UP; en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("pre_tick%0d", i), pt_w, ((i - 1) % 4 == 3) ? 1 : 0);
            tick();
            chk($sformatf("pre_out%0d", i), out_w, i / 4);
        end
        en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_count_reg.md
Name: load_count_reg

Overview:
- Parametrised successor to the team's 32-bit register/counter.
- Holds, loads, or counts up/down a WIDTH-bit value against a programmable limit.
- Wraps or saturates at the limit in hardware, with a registered terminal-count pulse and a sticky overflow flag.
- Sits in the datapath as a general event/loop counter, replacing bench-side "reset when out hits N" logic.

Parameters:
- WIDTH, 32, bit width of value, limit and load data.
- RST_VAL, 0, value taken by out on reset and on clear.
- SATURATE, 0, 0 = wrap at limit, 1 = saturate at limit/zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (rst=0 resets).
- clr  in  1  synchronous clear to RST_VAL, highest synchronous priority.
- load  in  1  synchronous load of in.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- in  in  WIDTH  load data.
- limit  in  WIDTH  terminal value, sampled every cycle.
- out  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle.
- ovf  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst=0, async): out=RST_VAL, tc=0, ovf=0. Outputs stay there until the first rising clk after rst=1.
- Synchronous priority per rising edge: clr > load > en > hold.
- clr=1: out=RST_VAL, tc=0, ovf=0.
- load=1: out=in, tc=0, ovf unchanged. If in>limit, load still happens; the next count step treats out>=limit as terminal.
- en=1, up=1:
  - out<limit: out=out+1.
  - out>=limit and SATURATE=0: out=0, tc=1, ovf=1.
  - out>=limit and SATURATE=1: out=limit, tc=1, ovf=1.
- en=1, up=0:
  - out>0: out=out-1.
  - out==0 and SATURATE=0: out=limit, tc=1, ovf=1.
  - out==0 and SATURATE=1: out=0, tc=1, ovf=1.
- Latency:
  - out reflects the operation one clock after sampling.
  - tc is asserted in the same cycle out shows the wrapped/saturated value.
  - tc is 0 in every other cycle; saturation re-asserts tc each enabled cycle.
- Arithmetic: unsigned, WIDTH bits. No carry escapes except via tc/ovf. limit=0 with up=1 gives tc every enabled cycle, out stays 0.
- ovf is cleared only by rst or clr.
- Reset mid-count: async; any in-flight tc is dropped.

Optional Feature:
- Macro PRESCALE_EN.
- Defined:
  - Adds parameter PRE_DIV (default 4, >=1) and port pre_tick (out, 1).
  - en is gated by an internal modulo-PRE_DIV prescaler: the count steps only on every PRE_DIV-th enabled cycle.
  - pre_tick pulses on those cycles.
  - The prescaler resets with rst and clr and is held while load=1.
- Not defined: en acts directly each cycle; no pre_tick port.

Decomposition:
- Package load_count_pkg:
  - direction constants DIR_UP=1, DIR_DN=0.
  - op encoding for assertions: OP_HOLD, OP_CLR, OP_LOAD, OP_CNT.
  - default WIDTH constant.
- One sub-module: load_count_prescaler, used only under PRESCALE_EN; contains the modulo counter and the tick output.

Test Plan:
1. Reset: hold rst=0 with in=7, load=1 for 3 clocks -> out=0, tc=0, ovf=0 throughout; after rst=1, next edge out=7.
2. Up-count wrap: limit=5, en=1, up=1 from 0 -> out 1,2,3,4,5,0; tc=1 only in the cycle out=0; ovf=1 thereafter.
3. Down-count wrap: load 2, limit=9, up=0, en=1 -> out 1,0,9; tc high with 9; ovf sticky.
4. Saturate (SATURATE=1): limit=3, count up from 0 for 6 cycles -> out 1,2,3,3,3,3; tc high on each of the last three cycles. clr -> out=0, ovf=0.
5. Priority: clr=1, load=1, en=1 together -> out=RST_VAL. load=1, en=1 with in=20 -> out=20, no increment.
6. Async reset mid-count: drop rst between edges while out=4 -> out=0 immediately (before next clk). PRESCALE_EN with PRE_DIV=4 -> out steps once per 4 enabled cycles, pre_tick aligned with each step.
